// File: rtl/multiaddr_decode_stream.sv
// Streaming multi-address decoder: registered per-index hit mask behind a 2-entry
// buffer, with a drain-then-swap shadow address map and a saturating error counter.
module multiaddr_decode_stream #(
    parameter int unsigned NoIndices   = 32'd4,
    parameter int unsigned NoRules     = 32'd4,
    parameter type         addr_t      = logic [31:0],
    // Packed rule layout, MSB first: {idx[31:0], start_addr, end_addr}
    parameter type         rule_t      = logic [32+2*$bits(addr_t)-1:0],
    parameter int unsigned ErrCntWidth = 32'd16,
    localparam int unsigned IdxW       = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  addr_t                          addr_i,
    input  logic                           addr_valid_i,
    output logic                           addr_ready_o,
    output logic [NoIndices-1:0]           mask_o,
    output logic                           dec_valid_o,
    output logic                           dec_error_o,
    output logic                           multi_hit_o,
    output logic                           mask_valid_o,
    input  logic                           mask_ready_i,
    input  logic [NoRules*$bits(rule_t)-1:0] addr_map_i,
    input  logic                           en_default_idx_i,
    input  logic [IdxW-1:0]                default_idx_i,
    input  logic                           map_update_i,
    output logic                           map_busy_o,
    output logic [ErrCntWidth-1:0]         err_cnt_o,
    input  logic                           err_cnt_clear_i
);

    localparam int unsigned AddrW = $bits(addr_t);
    localparam int unsigned RuleW = $bits(rule_t);
    localparam int unsigned EntW  = NoIndices + 3;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [NoRules*RuleW-1:0] map_q, map_d;
    logic                     en_def_q, en_def_d;
    logic [IdxW-1:0]          def_idx_q, def_idx_d;
    logic [0:0]               state_q, state_d;
    logic                     ready_q, ready_d;
    logic [EntW-1:0]          mem_q [2];
    logic [EntW-1:0]          mem_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [ErrCntWidth-1:0]   err_cnt_q, err_cnt_d;

    logic [RuleW-1:0]         rule_w;
    logic [NoIndices-1:0]     dec_mask;
    logic                     any_hit, dec_multi, dec_valid, dec_error;
    logic                     push, pop, count_err;

    always_comb begin
        rule_w    = '0;
        dec_mask  = '0;
        any_hit   = 1'b0;
        dec_multi = 1'b0;
        for (int unsigned r = 0; r < NoRules; r++) begin
            rule_w = map_q[r*RuleW +: RuleW];
            if ((addr_i >= rule_w[2*AddrW-1 -: AddrW]) && (addr_i < rule_w[AddrW-1:0]) &&
                (rule_w[RuleW-1 -: 32] < NoIndices)) begin
                dec_mask  = dec_mask | (NoIndices'(1) << rule_w[RuleW-1 -: 32]);
                dec_multi = dec_multi | any_hit;
                any_hit   = 1'b1;
            end
        end
        dec_valid = any_hit;
        dec_error = 1'b0;
        if (!any_hit) begin
            if (en_def_q && (32'(def_idx_q) < NoIndices)) begin
                dec_mask  = NoIndices'(1) << def_idx_q;
                dec_valid = 1'b1;
            end else begin
                dec_error = 1'b1;
            end
        end
    end

    always_comb begin
        push      = addr_valid_i && ready_q;
        pop       = (cnt_q != 2'd0) && mask_ready_i;
        count_err = push && dec_error;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {dec_mask, dec_valid, dec_error, dec_multi};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Swap only once the buffer has drained so queued entries keep old-map results
        state_d   = state_q;
        map_d     = map_q;
        en_def_d  = en_def_q;
        def_idx_d = def_idx_q;
        case (state_q)
            StIdle:  if (map_update_i) state_d = StDrain;
            StDrain: if (cnt_d == 2'd0) begin
                state_d   = StIdle;
                map_d     = addr_map_i;
                en_def_d  = en_default_idx_i;
                def_idx_d = default_idx_i;
            end
            default: state_d = StIdle;
        endcase
        ready_d = (cnt_d != 2'd2) && (state_d == StIdle);

        err_cnt_d = err_cnt_q;
        if (err_cnt_clear_i)
            err_cnt_d = count_err ? ErrCntWidth'(1) : '0;
        else if (count_err && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q     <= '0;
            en_def_q  <= 1'b0;
            def_idx_q <= '0;
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            map_q     <= map_d;
            en_def_q  <= en_def_d;
            def_idx_q <= def_idx_d;
            state_q   <= state_d;
            ready_q   <= ready_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign {mask_o, dec_valid_o, dec_error_o, multi_hit_o} = mem_q[rd_ptr_q];
    assign mask_valid_o = (cnt_q != 2'd0);
    assign addr_ready_o = ready_q;
    assign map_busy_o   = (state_q == StDrain);
    assign err_cnt_o    = err_cnt_q;

`ifndef SYNTHESIS
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mask_valid_o && !mask_ready_i |=> $stable({mask_o, dec_valid_o, dec_error_o, multi_hit_o}));
    a_map_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        map_busy_o && $past(map_busy_o) |-> $stable(addr_map_i));

    always @(posedge clk_i) begin
        if (rst_ni && (state_q == StDrain) && (cnt_d == 2'd0)) begin
            for (int unsigned r = 0; r < NoRules; r++) begin
                if (addr_map_i[r*RuleW + AddrW +: AddrW] >= addr_map_i[r*RuleW +: AddrW])
                    $warning("rule %0d loaded with start_addr >= end_addr", r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multiaddr_decode_stream.sv
// Directed bench for multiaddr_decode_stream: 4 indices, 3 rules, 2-bit error counter.
module tb_multiaddr_decode_stream;

    localparam int NR = 3;
    localparam int RW = 96;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   addr_i;
    logic          addr_valid_i;
    logic          addr_ready_o;
    logic [3:0]    mask_o;
    logic          dec_valid_o, dec_error_o, multi_hit_o, mask_valid_o;
    logic          mask_ready_i;
    logic [NR*RW-1:0] addr_map_i;
    logic          en_default_idx_i;
    logic [1:0]    default_idx_i;
    logic          map_update_i;
    logic          map_busy_o;
    logic [1:0]    err_cnt_o;
    logic          err_cnt_clear_i;

    int n_checks = 0;
    int n_fail   = 0;

    // {mask, dec_valid, dec_error, multi_hit}
    wire [6:0] head = {mask_o, dec_valid_o, dec_error_o, multi_hit_o};
    localparam logic [6:0] H_ERR  = 7'b0000_010;
    localparam logic [6:0] H_0001 = 7'b0001_100;
    localparam logic [6:0] H_0101 = 7'b0101_101;
    localparam logic [6:0] H_0100 = 7'b0100_100;
    localparam logic [6:0] H_1000 = 7'b1000_100;
    localparam logic [6:0] H_0110 = 7'b0110_101;

    multiaddr_decode_stream #(
        .NoIndices(4), .NoRules(NR), .ErrCntWidth(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .addr_valid_i(addr_valid_i),
        .addr_ready_o(addr_ready_o), .mask_o(mask_o), .dec_valid_o(dec_valid_o),
        .dec_error_o(dec_error_o), .multi_hit_o(multi_hit_o), .mask_valid_o(mask_valid_o),
        .mask_ready_i(mask_ready_i), .addr_map_i(addr_map_i),
        .en_default_idx_i(en_default_idx_i), .default_idx_i(default_idx_i),
        .map_update_i(map_update_i), .map_busy_o(map_busy_o), .err_cnt_o(err_cnt_o),
        .err_cnt_clear_i(err_cnt_clear_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [RW-1:0] rule(input logic [31:0] idx, input logic [31:0] s,
                                           input logic [31:0] e);
        return {idx, s, e};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a);
        addr_i       = a;
        addr_valid_i = 1'b1;
        cyc();
        addr_valid_i = 1'b0;
    endtask

    task automatic reload(input logic [31:0] r0_idx, input logic en, input logic [1:0] di);
        addr_map_i       = {rule(5, 32'h4000, 32'h5000), rule(2, 32'h1800, 32'h3000),
                            rule(r0_idx, 32'h1000, 32'h2000)};
        en_default_idx_i = en;
        default_idx_i    = di;
        map_update_i     = 1'b1;
        cyc();
        map_update_i = 1'b0;
        for (int i = 0; i < 20 && map_busy_o; i++) cyc();
        n_checks++;
        if (map_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_timeout: map_busy_o=%b want 0", map_busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cyc(); cyc();
        n_checks++;
        if ({mask_valid_o, map_busy_o, addr_ready_o, err_cnt_o, head} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/busy/ready/err/head=%b%b%b %0d %b want all 0",
                     mask_valid_o, map_busy_o, addr_ready_o, err_cnt_o, head);
        end
        rst_ni = 1'b1;
        cyc();
        n_checks++;
        if (addr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b want 1", addr_ready_o);
        end
    endtask

    task automatic test_first_decode();
        send(32'h1000);
        n_checks++;
        if ({mask_valid_o, head, err_cnt_o} !== {1'b1, H_ERR, 2'd1}) begin
            n_fail++;
            $display("FAIL empty_map_decode: v=%b head=%b cnt=%0d want 1 %b 1",
                     mask_valid_o, head, err_cnt_o, H_ERR);
        end
        reload(0, 1'b0, 2'd0);
        send(32'h1000);
        n_checks++;
        if ({mask_valid_o, head} !== {1'b1, H_0001}) begin
            n_fail++;
            $display("FAIL r0_decode: v=%b head=%b want 1 %b", mask_valid_o, head, H_0001);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'h1800, 32'h2FFF, 32'h3000};
        logic [6:0]  e [3] = '{H_0101, H_0100, H_ERR};
        for (int i = 0; i < 3; i++) begin
            addr_i       = a[i];
            addr_valid_i = 1'b1;
            n_checks++;
            if (addr_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, addr_ready_o);
            end
            cyc();
            n_checks++;
            if ({mask_valid_o, head} !== {1'b1, e[i]}) begin
                n_fail++;
                $display("FAIL b2b_head[%0d]: v=%b head=%b want 1 %b", i, mask_valid_o, head, e[i]);
            end
        end
        addr_valid_i = 1'b0;
        n_checks++;
        if (err_cnt_o !== 2'd2) begin
            n_fail++; $display("FAIL b2b_err_cnt: got %0d want 2", err_cnt_o);
        end
        cyc();
    endtask

    task automatic test_default_idx();
        send(32'h4800);
        n_checks++;
        if ({head, err_cnt_o} !== {H_ERR, 2'd3}) begin
            n_fail++;
            $display("FAIL oor_idx_error: head=%b cnt=%0d want %b 3", head, err_cnt_o, H_ERR);
        end
        reload(0, 1'b1, 2'd3);
        send(32'h4800);
        n_checks++;
        if ({mask_valid_o, head} !== {1'b1, H_1000}) begin
            n_fail++;
            $display("FAIL default_hit: v=%b head=%b want 1 %b", mask_valid_o, head, H_1000);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [31:0] a [5] = '{32'h1000, 32'h1800, 32'h2FFF, 32'h3000, 32'h4800};
        logic [6:0]  e [5] = '{H_0001, H_0101, H_0100, H_1000, H_1000};
        logic [6:0]  got [5];
        int sent = 0, rcvd = 0, extra = 0;
        logic was_ready;
        mask_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            addr_i = a[sent]; addr_valid_i = 1'b1; was_ready = addr_ready_o;
            cyc();
            if (was_ready) sent++;
        end
        n_checks++;
        if ({sent[2:0], addr_ready_o, mask_valid_o, head} !== {3'd2, 1'b0, 1'b1, H_0001}) begin
            n_fail++;
            $display("FAIL bp_hold: sent=%0d ready=%b v=%b head=%b want 2 0 1 %b",
                     sent, addr_ready_o, mask_valid_o, head, H_0001);
        end
        mask_ready_i = 1'b1;
        for (int c = 0; c < 30 && rcvd < 5; c++) begin
            if (mask_valid_o) begin got[rcvd] = head; rcvd++; end
            addr_valid_i = (sent < 5);
            addr_i       = a[(sent < 5) ? sent : 4];
            was_ready    = addr_ready_o && addr_valid_i;
            cyc();
            if (was_ready) sent++;
        end
        addr_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mask_valid_o) extra++;
            cyc();
        end
        n_checks++;
        if (rcvd !== 5 || extra !== 0) begin
            n_fail++; $display("FAIL bp_count: rcvd=%0d extra=%0d want 5 0", rcvd, extra);
        end
        for (int i = 0; i < rcvd; i++) begin
            n_checks++;
            if (got[i] !== e[i]) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %b want %b", i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_reload_drain();
        mask_ready_i = 1'b0;
        addr_i = 32'h1800; addr_valid_i = 1'b1;
        cyc();
        addr_i = 32'h3000;
        cyc();
        addr_valid_i     = 1'b0;
        addr_map_i       = {rule(5, 32'h4000, 32'h5000), rule(2, 32'h1800, 32'h3000),
                            rule(1, 32'h1000, 32'h2000)};
        en_default_idx_i = 1'b0;
        default_idx_i    = 2'd0;
        map_update_i     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            map_update_i = 1'b0;
            n_checks++;
            if ({map_busy_o, addr_ready_o, head} !== {1'b1, 1'b0, H_0101}) begin
                n_fail++;
                $display("FAIL drain_hold[%0d]: busy=%b ready=%b head=%b want 1 0 %b",
                         c, map_busy_o, addr_ready_o, head, H_0101);
            end
        end
        mask_ready_i = 1'b1;
        cyc();
        n_checks++;
        if ({map_busy_o, mask_valid_o, head} !== {1'b1, 1'b1, H_1000}) begin
            n_fail++;
            $display("FAIL drain_old_map: busy=%b v=%b head=%b want 1 1 %b",
                     map_busy_o, mask_valid_o, head, H_1000);
        end
        cyc();
        n_checks++;
        if ({map_busy_o, addr_ready_o, mask_valid_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL drain_done: busy=%b ready=%b v=%b want 0 1 0",
                     map_busy_o, addr_ready_o, mask_valid_o);
        end
        send(32'h1800);
        n_checks++;
        if (head !== H_0110) begin
            n_fail++; $display("FAIL new_map_decode: head=%b want %b", head, H_0110);
        end
        cyc();
    endtask

    task automatic test_err_cnt_and_reset();
        err_cnt_clear_i = 1'b1;
        cyc();
        err_cnt_clear_i = 1'b0;
        n_checks++;
        if (err_cnt_o !== 2'd0) begin
            n_fail++; $display("FAIL clear_alone: got %0d want 0", err_cnt_o);
        end
        addr_i = 32'h3000; addr_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (err_cnt_o !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
                n_fail++; $display("FAIL err_sat[%0d]: got %0d want %0d", i, err_cnt_o,
                                   (i < 3) ? i + 1 : 3);
            end
        end
        err_cnt_clear_i = 1'b1;
        cyc();
        err_cnt_clear_i = 1'b0;
        addr_valid_i    = 1'b0;
        n_checks++;
        if (err_cnt_o !== 2'd1) begin
            n_fail++; $display("FAIL clear_with_err: got %0d want 1", err_cnt_o);
        end
        cyc();
        mask_ready_i = 1'b0;
        addr_valid_i = 1'b1;
        cyc(); cyc();
        addr_valid_i = 1'b0;
        map_update_i = 1'b1;
        cyc();
        map_update_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({mask_valid_o, map_busy_o, err_cnt_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: v=%b busy=%b cnt=%0d want 0 0 0",
                     mask_valid_o, map_busy_o, err_cnt_o);
        end
        cyc();
        rst_ni       = 1'b1;
        mask_ready_i = 1'b1;
        cyc();
        send(32'h1800);
        n_checks++;
        if ({head, err_cnt_o} !== {H_ERR, 2'd1}) begin
            n_fail++;
            $display("FAIL map_cleared_by_reset: head=%b cnt=%0d want %b 1", head, err_cnt_o, H_ERR);
        end
    endtask

    initial begin
        rst_ni = 1'b0; addr_i = '0; addr_valid_i = 1'b0; mask_ready_i = 1'b1;
        addr_map_i = '0; en_default_idx_i = 1'b0; default_idx_i = '0;
        map_update_i = 1'b0; err_cnt_clear_i = 1'b0;
        test_reset();
        test_first_decode();
        test_back_to_back();
        test_default_idx();
        test_backpressure();
        test_reload_drain();
        test_err_cnt_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
